// File: rtl/mmm_nlp_pkg.sv
// Shared constants, FSM state type and counter sizing for the NLP
// Montgomery reduction stage.
//   WW   : reduction word width (radix 2^16)
//   ITER : reduction iterations, R = 2^(WW*ITER) = 2^96
//   DW   : modulus / result width
//   PW   : product input width
//   AW   : accumulator width (PW + 1)
package mmm_nlp_pkg;

  localparam int unsigned WW   = 16;
  localparam int unsigned ITER = 6;
  localparam int unsigned DW   = 90;
  localparam int unsigned PW   = 181;
  localparam int unsigned AW   = 182;

  // Smallest r with 2^r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter reaches ITER after the last increment, so size for ITER itself.
  localparam int unsigned CW = clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mmm_nlp_redc_step.sv
// One combinational word-serial Montgomery iteration:
//   q = acc[15:0] * ninv mod 2^16 ; acc_o = (acc + q*n) >> 16
// Ports:
//   acc_i  : current accumulator (AW bits)
//   n_i    : modulus N (DW bits)
//   ninv_i : -N^-1 mod 2^16
//   acc_o  : accumulator after this iteration
module mmm_nlp_redc_step
  import mmm_nlp_pkg::*;
(
  input  logic [AW-1:0] acc_i,
  input  logic [DW-1:0] n_i,
  input  logic [WW-1:0] ninv_i,
  output logic [AW-1:0] acc_o
);

  logic [WW-1:0]    q;
  logic [DW+WW-1:0] qn;
  logic [AW:0]      sum;

  assign q   = WW'(acc_i[WW-1:0] * ninv_i);
  assign qn  = (DW+WW)'(q) * (DW+WW)'(n_i);
  // Sum kept one bit wider than the accumulator; low WW bits are zero by choice of q.
  assign sum = (AW+1)'(acc_i) + (AW+1)'(qn);
  assign acc_o = AW'(sum >> WW);

endmodule

// File: rtl/mmm_nlp_redc_90b.sv
// Word-serial Montgomery reduction of a 181-bit product T, producing
// T * 2^-96 mod N in non-least-positive form [0, 2N).
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid / o_ready : product handshake (i_res, i_n, i_ninv captured on accept)
//   i_res             : product T (PW bits)
//   i_n               : odd modulus N (DW bits)
//   i_ninv            : -N^-1 mod 2^16
//   o_valid / i_ready : result handshake
//   o_res             : reduced result (DW bits)
//   o_ovf             : accumulator bits above DW were nonzero at completion
module mmm_nlp_redc_90b
  import mmm_nlp_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [PW-1:0] i_res,
  input  logic [DW-1:0] i_n,
  input  logic [WW-1:0] i_ninv,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_res,
  output logic          o_ovf
);

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [DW-1:0] n_q;
  logic [WW-1:0] ninv_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          valid_q;
  logic [DW-1:0] res_q;
  logic          ovf_q;

  // Single shared iteration datapath.
  mmm_nlp_redc_step u_step (
    .acc_i  (acc_q),
    .n_i    (n_q),
    .ninv_i (ninv_q),
    .acc_o  (acc_d)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      ninv_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            acc_q   <= AW'(i_res);
            n_q     <= i_n;
            ninv_q  <= i_ninv;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          // Result is captured from the final iteration's output directly.
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            res_q   <= acc_d[DW-1:0];
            ovf_q   <= |acc_d[AW-1:DW];
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_res   = res_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_mmm_nlp_redc_90b.sv
// Self-checking bench for mmm_nlp_redc_90b: directed corner cases plus
// randomized products checked against a whole-word Montgomery model.
module tb_mmm_nlp_redc_90b;
  import mmm_nlp_pkg::*;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [PW-1:0] t_in;
  logic [DW-1:0] n_in;
  logic [WW-1:0] ninv_in;
  logic          out_valid;
  logic          in_ready;
  logic [DW-1:0] res_out;
  logic          ovf_out;

  mmm_nlp_redc_90b dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_res   (t_in),
    .i_n     (n_in),
    .i_ninv  (ninv_in),
    .o_valid (out_valid),
    .i_ready (in_ready),
    .o_res   (res_out),
    .o_ovf   (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [PW-1:0] t;
    logic [DW-1:0] n;
    logic [DW-1:0] res;
    logic          ovf;
    int            acc_edge;
  } exp_t;

  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // -N^-1 mod 2^96 by Newton iteration on the 2-adic inverse.
  function automatic logic [95:0] nprime96(input logic [DW-1:0] n);
    logic [95:0] inv;
    inv = 96'(n);
    for (int i = 0; i < 6; i++) inv = inv * (96'd2 - 96'(n) * inv);
    return 96'd0 - inv;
  endfunction

  function automatic logic [WW-1:0] ninv16(input logic [DW-1:0] n);
    logic [95:0] np;
    np = nprime96(n);
    return np[WW-1:0];
  endfunction

  // Whole-word REDC: (T + m*N) / 2^96 with m = T * N' mod 2^96.
  function automatic logic [103:0] model(input logic [PW-1:0] t, input logic [DW-1:0] n);
    logic [95:0]  m;
    logic [199:0] s;
    m = 96'(t) * nprime96(n);
    s = 200'(t) + 200'(m) * 200'(n);
    return 104'(s >> 96);
  endfunction

  // Scoreboard: record accepts, check every presented result and its stability.
  bit            was_valid = 1'b0;
  logic [DW-1:0] held_res;
  logic          held_ovf;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      check("ready_low_while_valid", 200'(out_ready), 200'(0));
      if (!was_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 200'(1), 200'(0));
        end else begin
          e = exp_q.pop_front();
          check("res", 200'(res_out), 200'(e.res));
          check("ovf", 200'(ovf_out), 200'(e.ovf));
          check("latency", 200'(cyc - e.acc_edge), 200'(ITER));
          if (200'(e.t) < (200'(e.n) << 96)) begin
            check("res_lt_2n", 200'(200'(res_out) < (200'(e.n) << 1)), 200'(1));
            check("congruence", (200'(res_out) << 96) % 200'(e.n), 200'(e.t) % 200'(e.n));
          end
        end
      end else begin
        check("hold_res", 200'(res_out), 200'(held_res));
        check("hold_ovf", 200'(ovf_out), 200'(held_ovf));
      end
    end
    was_valid = out_valid;
    held_res  = res_out;
    held_ovf  = ovf_out;
    if (rst) begin
      exp_q.delete();
      was_valid = 1'b0;
    end else if (in_valid && out_ready) begin
      logic [103:0] mr;
      mr = model(t_in, n_in);
      e.t = t_in;
      e.n = n_in;
      e.res = mr[DW-1:0];
      e.ovf = |mr[103:DW];
      e.acc_edge = cyc + 1;
      exp_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) in_ready = ($urandom % 4) != 0;
  endtask

  task automatic run_one(input logic [PW-1:0] t, input logic [DW-1:0] n, input logic [WW-1:0] ni);
    int k;
    k = 0;
    while (!out_ready && k < 100) begin
      step();
      k++;
    end
    if (!out_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
      return;
    end
    t_in = t;
    n_in = n;
    ninv_in = ni;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int k;
    k = 0;
    while (!out_valid && k < maxc) begin
      step();
      k++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got 0 expected 1");
    end
  endtask

  logic [PW-1:0] t96;
  logic [103:0]  mtmp;

  initial begin
    t96 = PW'(1) << 96;
    rst = 1'b1;
    in_valid = 1'b1;
    in_ready = 1'b1;
    t_in = t96;
    n_in = 90'd3;
    ninv_in = 16'h5555;

    // Model pinned against hand-computed values.
    check("model_ninv_3", 200'(ninv16(90'd3)), 200'h5555);
    mtmp = model(t96, 90'd3);
    check("model_shift", 200'(mtmp), 200'd1);
    mtmp = model(PW'(1), 90'd3);
    check("model_carry", 200'(mtmp), 200'd1);

    // Reset held two clocks with i_valid high.
    step();
    step();
    check("rst_ready", 200'(out_ready), 200'(1));
    check("rst_valid", 200'(out_valid), 200'(0));
    check("rst_res", 200'(res_out), 200'(0));
    check("rst_ovf", 200'(ovf_out), 200'(0));
    rst = 1'b0;
    in_valid = 1'b0;

    // Exact shift: q = 0 every iteration.
    run_one(t96, 90'd3, 16'h5555);
    for (int i = 0; i < ITER; i++) step();
    check("shift_valid", 200'(out_valid), 200'(1));
    check("shift_res", 200'(res_out), 200'd1);
    check("shift_ovf", 200'(ovf_out), 200'(0));
    step();
    check("shift_idle_ready", 200'(out_ready), 200'(1));

    // Carry path: accumulator returns to 1 after every iteration.
    run_one(PW'(1), 90'd3, 16'h5555);
    for (int i = 0; i < ITER; i++) begin
      step();
      check("carry_acc", 200'(dut.acc_q), 200'd1);
    end
    check("carry_valid", 200'(out_valid), 200'(1));
    check("carry_res", 200'(res_out), 200'd1);
    step();

    // Backpressure with i_valid pulsing while the result is held.
    in_ready = 1'b0;
    run_one(t96, 90'd3, 16'h5555);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      step();
      check("bp_valid", 200'(out_valid), 200'(1));
      check("bp_ready", 200'(out_ready), 200'(0));
      check("bp_res", 200'(res_out), 200'd1);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    step();
    check("bp_release_valid", 200'(out_valid), 200'(0));
    check("bp_release_ready", 200'(out_ready), 200'(1));

    // Reset during RUN: result is discarded.
    run_one(PW'(12345), 90'd3, 16'h5555);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", 200'(out_ready), 200'(1));
    check("midrst_valid", 200'(out_valid), 200'(0));
    for (int i = 0; i < 10; i++) step();
    check("midrst_no_valid", 200'(out_valid), 200'(0));
    run_one(t96, 90'd3, 16'h5555);
    wait_valid(20);
    check("postrst_res", 200'(res_out), 200'd1);
    step();

    // Randomized products with random downstream backpressure.
    rand_rdy = 1'b1;
    for (int trial = 0; trial < 1000; trial++) begin
      logic [95:0]  r;
      logic [191:0] ra;
      logic [191:0] rb;
      logic [DW-1:0] n;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int sh;
      r  = {$urandom(), $urandom(), $urandom()};
      sh = $urandom_range(0, 80);
      n  = DW'(r[87:0] >> sh) | 90'd1;
      if (n < 90'd3) n = 90'd3;
      ra = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      a  = DW'(ra % (192'(n) << 1));
      b  = DW'(rb % (192'(n) << 1));
      if (trial % 97 == 0) begin
        a = DW'((192'(n) << 1) - 192'd1);
        b = a;
      end
      run_one(PW'(a) * PW'(b), n, ninv16(n));
    end

    // Drain outstanding result.
    rand_rdy = 1'b0;
    in_ready = 1'b1;
    for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid); k++) step();
    check("drain_empty", 200'(exp_q.size()), 200'(0));
    check("drain_valid", 200'(out_valid), 200'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
